dm_arbiter: RTL and testbench
=============================

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
- REQ-001: Parameter ADDR_W, default 9, data-memory word-address width.
- REQ-002: Parameter DATA_W, default 16, data-memory word width.
- REQ-003: Parameter STARVE_LIMIT, default 4, maximum consecutive contended CPU grants before the host is forced a grant (range 1..15).
- REQ-004: clk  input  1  system clock, rising-edge active.
- REQ-005: rst  input  1  asynchronous, active-low reset.
- REQ-006: cpu_req / cpu_we  input  1 / 1  CPU access request and write enable (load, store, push, pop).
- REQ-007: cpu_addr / cpu_wdata  input  ADDR_W / DATA_W  CPU address and write data.
- REQ-008: cpu_gnt / cpu_stall  output  1 / 1  CPU access accepted this cycle / CPU must hold its request and freeze the PC.
- REQ-009: cpu_rdata / cpu_rvalid  output  DATA_W / 1  registered read data and its one-cycle valid strobe.
- REQ-010: host_req / host_we / host_lock  input  1 / 1 / 1  host (debug/DMA) request, write enable, and burst-lock hold.
- REQ-011: host_addr / host_wdata  input  ADDR_W / DATA_W  host address and write data.
- REQ-012: host_gnt / host_rdata / host_rvalid  output  1 / DATA_W / 1  host grant, registered read data, and read valid.
- REQ-013: mem_w / mem_addr / mem_wdata  output  1 / ADDR_W / DATA_W  data-memory write strobe, address, and write data.
- REQ-014: mem_rdata  input  DATA_W  data-memory combinational read data for mem_addr.

Function
- REQ-015: At most one of cpu_gnt and host_gnt SHALL be high in any cycle; each grant is combinational from the requests and registered state.
- REQ-016: mem_addr, mem_wdata, and mem_w SHALL mux from the granted port; with no grant: mem_w=0, mem_addr=0, mem_wdata=0.
- REQ-017: A granted read SHALL capture mem_rdata into that port's rdata register at the grant edge and pulse that port's rvalid high for exactly the next cycle.
- REQ-018: rdata registers SHALL hold their value until the next granted read on the same port.
- REQ-019: cpu_stall SHALL equal cpu_req AND NOT cpu_gnt.
- REQ-020: FSM states: IDLE, CPU, HOST, LOCK, encoding the previous cycle's owner.
- REQ-021: Transitions: to CPU on cpu_gnt, to HOST on host_gnt without lock, to LOCK on host_gnt with host_lock, else to IDLE.
- REQ-022: In LOCK, the host SHALL be granted whenever host_req=1, and the CPU SHALL be stalled.
- REQ-023: LOCK SHALL be left, to IDLE, on the first cycle with host_lock=0 or host_req=0.
- REQ-024: Sole requester SHALL be granted immediately, zero-latency.
- REQ-025: Contention, default policy: CPU wins. 4-bit starve_cnt increments per contended CPU grant.
- REQ-026: When starve_cnt==STARVE_LIMIT, the host SHALL win the next contended cycle; starve_cnt clears on any host grant.
- REQ-027: starve_cnt SHALL saturate and never wrap.
- REQ-028: Request dropped before grant: no memory access, no rvalid, no state change except the FSM returning to IDLE.

Reset
- REQ-029: While rst=0: FSM=IDLE, starve_cnt=0, all grants/rvalid/stall/mem_w=0, cpu_rdata=host_rdata=0, asynchronously.
- REQ-030: A reset mid-LOCK or mid-read SHALL abort it with no rvalid issued after release.

Configuration
- REQ-031: Macro DM_ARB_ROUND_ROBIN_EN defined: contention alternates strictly, the port not granted most recently wins, starve_cnt is removed, and STARVE_LIMIT is ignored.
- REQ-032: Macro DM_ARB_ROUND_ROBIN_EN undefined: CPU priority with starvation limit per REQ-025..027.
- REQ-033: LOCK behaviour SHALL be identical in both builds.

Structure
- REQ-034: Shared package holds FSM state typedef (IDLE/CPU/HOST/LOCK) and the default ADDR_W/DATA_W constants, shared with core and memory.
- REQ-035: Single module, with no sub-module; the read-return register pair stays inline.

Verification
- REQ-036: CPU-only read: cpu_req=1, cpu_addr=0x010, mem holds 0x1234 -> cpu_gnt same cycle, next cycle cpu_rvalid=1 and cpu_rdata=0x1234, cpu_stall=0.
- REQ-037: Host-only write: host_we=1, host_addr=0x1FF, host_wdata=0xBEEF -> mem_w=1, mem_addr=0x1FF, mem_wdata=0xBEEF in the grant cycle.
- REQ-038: Continuous contention, default build, STARVE_LIMIT=4 -> grant pattern C,C,C,C,H repeating; cpu_stall=1 only on H cycles.
- REQ-039: Same stimulus with DM_ARB_ROUND_ROBIN_EN -> grants alternate H,C,H,C starting with H after reset, since CPU is treated as last granted.
- REQ-040: Host lock for 3 cycles with cpu_req=1 throughout -> 3 host grants, cpu_stall=1 all 3; CPU granted on the cycle host_lock falls.
- REQ-041: Assert rst=0 during a granted host read -> host_rvalid stays 0 and all outputs are 0 immediately.

Source files
------------

// File: rtl/dm_arbiter_pkg.sv
// Shared data-memory arbiter types: owner-state encoding and default bus widths.
// Used by the arbiter, the core-side port logic and the memory model.
package dm_arbiter_pkg;

  localparam int DM_ADDR_W = 9;
  localparam int DM_DATA_W = 16;
  localparam int STARVE_W  = 4;

  // Owner of the memory port in the previous cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CPU  = 2'd1,
    HOST = 2'd2,
    LOCK = 2'd3
  } arb_state_t;

  function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// CPU, host and data-memory signal bundle around the arbiter.
// slave = arbiter side, master = requesters plus memory.
interface dm_arbiter_if
  import dm_arbiter_pkg::*;
#(
  parameter int ADDR_W = DM_ADDR_W,
  parameter int DATA_W = DM_DATA_W
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_stall;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;

  logic              host_req;
  logic              host_we;
  logic              host_lock;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvalid;

  logic              mem_w;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_stall, cpu_rdata, cpu_rvalid,
    input  host_req, host_we, host_lock, host_addr, host_wdata,
    output host_gnt, host_rdata, host_rvalid,
    output mem_w, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_stall, cpu_rdata, cpu_rvalid,
    output host_req, host_we, host_lock, host_addr, host_wdata,
    input  host_gnt, host_rdata, host_rvalid,
    input  mem_w, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dm_arbiter.sv
// Two-port (CPU/host) data-memory arbiter: zero-latency grants, host burst lock, registered read return.
// Default CPU priority with starvation limit; define DM_ARB_ROUND_ROBIN_EN for strict alternation.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DM_ADDR_W,
  parameter int DATA_W       = DM_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  dm_arbiter_if.slave     bus
);

  arb_state_t        state;
  logic              cpu_gnt;
  logic              host_gnt;
  logic              host_wins;
  logic              contended;
  logic              lock_hold;
  logic              mux_w;
  logic [ADDR_W-1:0] mux_addr;
  logic [DATA_W-1:0] mux_wdata;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] host_rdata_q;
  logic              cpu_rvalid_q;
  logic              host_rvalid_q;

`ifdef DM_ARB_ROUND_ROBIN_EN
  // Cleared at reset, so the CPU counts as most recently granted.
  logic last_host;
  assign host_wins = ~last_host;
`else
  logic [STARVE_W-1:0] starve_cnt;
  assign host_wins = (starve_cnt == STARVE_W'(STARVE_LIMIT));
`endif

  assign lock_hold = (state == LOCK) && bus.host_req && bus.host_lock;
  assign contended = bus.cpu_req && bus.host_req;

  // Grants are gated by rst so they drop the instant reset asserts.
  always_comb begin
    cpu_gnt  = 1'b0;
    host_gnt = 1'b0;
    if (rst) begin
      if (lock_hold) begin
        host_gnt = 1'b1;
      end else if (contended) begin
        host_gnt = host_wins;
        cpu_gnt  = ~host_wins;
      end else begin
        cpu_gnt  = bus.cpu_req;
        host_gnt = bus.host_req;
      end
    end
  end

  always_comb begin
    mux_w     = 1'b0;
    mux_addr  = '0;
    mux_wdata = '0;
    if (cpu_gnt) begin
      mux_w     = bus.cpu_we;
      mux_addr  = bus.cpu_addr;
      mux_wdata = bus.cpu_wdata;
    end else if (host_gnt) begin
      mux_w     = bus.host_we;
      mux_addr  = bus.host_addr;
      mux_wdata = bus.host_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cpu_rdata_q   <= '0;
      host_rdata_q  <= '0;
      cpu_rvalid_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
`ifdef DM_ARB_ROUND_ROBIN_EN
      last_host     <= 1'b0;
`else
      starve_cnt    <= '0;
`endif
    end else begin
      if (cpu_gnt)                        state <= CPU;
      else if (host_gnt && bus.host_lock) state <= LOCK;
      else if (host_gnt)                  state <= HOST;
      else                                state <= IDLE;

      cpu_rvalid_q  <= cpu_gnt && !bus.cpu_we;
      host_rvalid_q <= host_gnt && !bus.host_we;
      if (cpu_gnt && !bus.cpu_we)   cpu_rdata_q  <= bus.mem_rdata;
      if (host_gnt && !bus.host_we) host_rdata_q <= bus.mem_rdata;

`ifdef DM_ARB_ROUND_ROBIN_EN
      if (cpu_gnt || host_gnt) last_host <= host_gnt;
`else
      if (host_gnt)                         starve_cnt <= '0;
      else if (cpu_gnt && bus.host_req)     starve_cnt <= sat_inc(starve_cnt);
`endif
    end
  end

  assign bus.cpu_gnt     = cpu_gnt;
  assign bus.host_gnt    = host_gnt;
  assign bus.cpu_stall   = rst && bus.cpu_req && !cpu_gnt;
  assign bus.mem_w       = mux_w;
  assign bus.mem_addr    = mux_addr;
  assign bus.mem_wdata   = mux_wdata;
  assign bus.cpu_rdata   = cpu_rdata_q;
  assign bus.host_rdata  = host_rdata_q;
  assign bus.cpu_rvalid  = cpu_rvalid_q;
  assign bus.host_rvalid = host_rvalid_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: vector table for single-port traffic, hand sequences for
// contention, lock and reset corners. Memory is a simple model behind mem_addr.
module tb_dm_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  dm_arbiter_if bus ();

  dm_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem [512];
  logic        pl_en;
  logic [8:0]  pl_addr;
  logic [15:0] pl_dat;

  always @(posedge clk) begin
    if (pl_en)          mem[pl_addr]      <= pl_dat;
    else if (bus.mem_w) mem[bus.mem_addr] <= bus.mem_wdata;
  end
  assign bus.mem_rdata = mem[bus.mem_addr];

  typedef struct {
    logic        cr, cw;
    logic [8:0]  ca;
    logic [15:0] cd;
    logic        hr, hw, hl;
    logic [8:0]  ha;
    logic [15:0] hd;
    logic        e_cg, e_hg, e_st, e_mw;
    logic [8:0]  e_ma;
    logic [15:0] e_md;
    logic        e_crv;
    logic [15:0] e_crd;
    logic        e_hrv;
    logic [15:0] e_hrd;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.host_req = 0; bus.host_we = 0; bus.host_lock = 0; bus.host_addr = '0; bus.host_wdata = '0;
  endtask

  // Leaves the bench at posedge+1 of the first cycle after release.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    pl_en  = 1'b1;
    pl_addr = 9'h010; pl_dat = 16'h1234;
    idle_inputs();
    bus.cpu_req = 1; bus.cpu_we = 1; bus.host_req = 1;
    bus.cpu_addr = 9'h0AB; bus.host_addr = 9'h0CD;
    @(posedge clk); #1;
    pl_addr = 9'h020; pl_dat = 16'h5678;
    @(posedge clk); #1;
    pl_en = 1'b0;

    // Outputs held low while reset is asserted, even with requests present.
    chk("rst_cpu_gnt",    32'(bus.cpu_gnt),    0);
    chk("rst_host_gnt",   32'(bus.host_gnt),   0);
    chk("rst_cpu_stall",  32'(bus.cpu_stall),  0);
    chk("rst_mem_w",      32'(bus.mem_w),      0);
    chk("rst_mem_addr",   32'(bus.mem_addr),   0);
    chk("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 0);
    chk("rst_host_rvalid",32'(bus.host_rvalid),0);
    chk("rst_cpu_rdata",  32'(bus.cpu_rdata),  0);
    chk("rst_host_rdata", 32'(bus.host_rdata), 0);

    vecs[0] = '{1,0,9'h010,16'h1111, 0,0,0,9'h000,16'h0000, 1,0,0,0,9'h010,16'h1111, 1,16'h1234, 0,16'h0000};
    vecs[1] = '{0,0,9'h000,16'h0000, 1,1,1,9'h1FF,16'hBEEF, 0,1,0,1,9'h1FF,16'hBEEF, 0,16'h1234, 0,16'h0000};
    vecs[2] = '{0,0,9'h000,16'h0000, 1,0,0,9'h1FF,16'h0F0F, 0,1,0,0,9'h1FF,16'h0F0F, 0,16'h1234, 1,16'hBEEF};
    vecs[3] = '{1,1,9'h0AA,16'h7777, 0,0,0,9'h000,16'h0000, 1,0,0,1,9'h0AA,16'h7777, 0,16'h1234, 0,16'hBEEF};
    vecs[4] = '{0,1,9'h055,16'h9999, 0,1,0,9'h066,16'h8888, 0,0,0,0,9'h000,16'h0000, 0,16'h1234, 0,16'hBEEF};
    vecs[5] = '{1,0,9'h0AA,16'h0000, 0,0,0,9'h000,16'h0000, 1,0,0,0,9'h0AA,16'h0000, 1,16'h7777, 0,16'hBEEF};
    vecs[6] = '{0,0,9'h000,16'h0000, 1,0,0,9'h020,16'h0000, 0,1,0,0,9'h020,16'h0000, 0,16'h7777, 1,16'h5678};

    do_reset();
    for (int i = 0; i < 7; i++) begin
      bus.cpu_req = vecs[i].cr; bus.cpu_we = vecs[i].cw;
      bus.cpu_addr = vecs[i].ca; bus.cpu_wdata = vecs[i].cd;
      bus.host_req = vecs[i].hr; bus.host_we = vecs[i].hw; bus.host_lock = vecs[i].hl;
      bus.host_addr = vecs[i].ha; bus.host_wdata = vecs[i].hd;
      @(negedge clk);
      chk($sformatf("v%0d_cpu_gnt", i),   32'(bus.cpu_gnt),   32'(vecs[i].e_cg));
      chk($sformatf("v%0d_host_gnt", i),  32'(bus.host_gnt),  32'(vecs[i].e_hg));
      chk($sformatf("v%0d_cpu_stall", i), 32'(bus.cpu_stall), 32'(vecs[i].e_st));
      chk($sformatf("v%0d_mem_w", i),     32'(bus.mem_w),     32'(vecs[i].e_mw));
      chk($sformatf("v%0d_mem_addr", i),  32'(bus.mem_addr),  32'(vecs[i].e_ma));
      chk($sformatf("v%0d_mem_wdata", i), 32'(bus.mem_wdata), 32'(vecs[i].e_md));
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      chk($sformatf("v%0d_cpu_rvalid", i),  32'(bus.cpu_rvalid),  32'(vecs[i].e_crv));
      chk($sformatf("v%0d_cpu_rdata", i),   32'(bus.cpu_rdata),   32'(vecs[i].e_crd));
      chk($sformatf("v%0d_host_rvalid", i), 32'(bus.host_rvalid), 32'(vecs[i].e_hrv));
      chk($sformatf("v%0d_host_rdata", i),  32'(bus.host_rdata),  32'(vecs[i].e_hrd));
      @(posedge clk); #1;
    end

    // Continuous contention from reset.
    do_reset();
    bus.cpu_req = 1; bus.cpu_addr = 9'h010;
    bus.host_req = 1; bus.host_addr = 9'h020;
    for (int i = 0; i < 10; i++) begin
      logic exp_h;
`ifdef DM_ARB_ROUND_ROBIN_EN
      exp_h = (i % 2) == 0;
`else
      exp_h = (i % 5) == 4;
`endif
      @(negedge clk);
      chk($sformatf("cont%0d_host_gnt", i),  32'(bus.host_gnt),  32'(exp_h));
      chk($sformatf("cont%0d_cpu_gnt", i),   32'(bus.cpu_gnt),   32'(!exp_h));
      chk($sformatf("cont%0d_cpu_stall", i), 32'(bus.cpu_stall), 32'(exp_h));
      @(posedge clk); #1;
    end

    // Host lock burst against a continuously requesting CPU.
    do_reset();
    bus.cpu_req = 1; bus.cpu_addr = 9'h010;
    bus.host_req = 1; bus.host_lock = 1; bus.host_addr = 9'h020;
    begin
      int  waited;
      logic seen;
      waited = 0;
      seen   = 1'b0;
      while (!seen && waited < 8) begin
        @(negedge clk);
        if (bus.host_gnt) seen = 1'b1;
        else begin
          @(posedge clk); #1;
          waited++;
        end
      end
      chk("lock_first_grant_seen", 32'(seen), 1);
      chk("lock0_cpu_stall", 32'(bus.cpu_stall), 1);
      for (int k = 1; k < 3; k++) begin
        @(posedge clk); #1;
        @(negedge clk);
        chk($sformatf("lock%0d_host_gnt", k),  32'(bus.host_gnt),  1);
        chk($sformatf("lock%0d_cpu_gnt", k),   32'(bus.cpu_gnt),   0);
        chk($sformatf("lock%0d_cpu_stall", k), 32'(bus.cpu_stall), 1);
      end
      @(posedge clk); #1;
      bus.host_lock = 0;
      @(negedge clk);
      chk("unlock_cpu_gnt",   32'(bus.cpu_gnt),   1);
      chk("unlock_host_gnt",  32'(bus.host_gnt),  0);
      chk("unlock_cpu_stall", 32'(bus.cpu_stall), 0);
      @(posedge clk); #1;
    end

    // Reset asserted in the middle of a granted host read.
    do_reset();
    bus.host_req = 1; bus.host_addr = 9'h020;
    @(negedge clk);
    chk("rmid_host_gnt_before", 32'(bus.host_gnt), 1);
    rst = 1'b0;
    #1;
    chk("rmid_host_gnt",    32'(bus.host_gnt),    0);
    chk("rmid_mem_addr",    32'(bus.mem_addr),    0);
    chk("rmid_host_rvalid", 32'(bus.host_rvalid), 0);
    chk("rmid_host_rdata",  32'(bus.host_rdata),  0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rmid_post_rvalid", 32'(bus.host_rvalid), 0);
    chk("rmid_post_rdata",  32'(bus.host_rdata),  0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
